// File: rtl/ex_pkg.sv
// Execute-stage shared definitions: ALU operation codes, mul/div FSM states.
package ex_pkg;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  localparam int unsigned MULDIV_STEPS = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_FIX
  } md_state_t;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative 32-step multiply / restoring divide with HI/LO result registers.
module ex_muldiv
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state, state_next;
  logic [4:0]  cnt;
  logic [31:0] acc_hi, acc_lo, mcand;
  logic        is_div, neg_a, neg_b, div0;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [33:0] div_trial;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;

  assign busy = (state != MD_IDLE);

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_mag     = (signed_op && a[31]) ? -a : a;
    b_mag     = (signed_op && b[31]) ? -b : b;

    // mul: {acc_hi,acc_lo} shifts right with the multiplier in acc_lo;
    // div: acc_hi is the partial remainder, acc_lo collects quotient bits
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
    div_sh    = {acc_hi, acc_lo[31]};
    div_trial = {1'b0, div_sh} - {2'b00, mcand};
    if (is_div) begin
      step_hi = div_trial[33] ? div_sh[31:0] : div_trial[31:0];
      step_lo = {acc_lo[30:0], ~div_trial[33]};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo[31:1]};
    end

    prod_fix = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    q_fix    = div0 ? '1 : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
    r_fix    = neg_a ? -acc_hi : acc_hi;

    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (cnt == 5'(MULDIV_STEPS - 1)) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_next;
      case (state)
        MD_IDLE: if (start) begin
          acc_hi <= '0;
          acc_lo <= a_mag;
          mcand  <= b_mag;
          is_div <= (op == OP_DIV) || (op == OP_DIVU);
          neg_a  <= signed_op & a[31];
          neg_b  <= signed_op & b[31];
          div0   <= (b == '0);
          cnt    <= '0;
        end
        MD_BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
        end
        MD_FIX: begin
          // divide by zero leaves the dividend in acc_hi, so r_fix restores it
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution, EX/MEM register; mul/div unit and
// stall logic present only when EX_MULDIV_EN is defined.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch,
  input  logic             jump,
  input  logic             AluSrc,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             RegWrite,
  input  logic             RegDst,
  input  logic             MemtoReg,
  input  logic [5:0]       AluOp,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] readdata1,
  input  logic [WIDTH-1:0] readdata2,
  input  logic [WIDTH-1:0] sigext,
  input  logic [4:0]       instruction_2016,
  input  logic [4:0]       instruction_1511,
  output logic             stall,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] writedata_out,
  output logic [WIDTH-1:0] branch_target_out,
  output logic [4:0]       write_reg_out,
  output logic             branch_taken_out,
  output logic             jump_out,
  output logic             MemRead_out,
  output logic             MemWrite_out,
  output logic             RegWrite_out,
  output logic             MemtoReg_out
);

  logic [WIDTH-1:0] op_b, alu_res, hi_val, lo_val;
  logic [4:0]       shamt;

`ifdef EX_MULDIV_EN
  logic md_busy, md_start, is_md, is_mf;

  assign is_md    = is_muldiv_op(AluOp);
  assign is_mf    = (AluOp == OP_MFHI) || (AluOp == OP_MFLO);
  assign stall    = md_busy & (is_md | is_mf);
  assign md_start = is_md & ~md_busy;

  ex_muldiv u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (AluOp),
    .a     (readdata1),
    .b     (readdata2),
    .busy  (md_busy),
    .hi    (hi_val),
    .lo    (lo_val)
  );
`else
  assign stall  = 1'b0;
  assign hi_val = '0;
  assign lo_val = '0;
`endif

  always_comb begin
    op_b  = AluSrc ? sigext : readdata2;
    shamt = sigext[10:6];
    case (AluOp)
      OP_ADD:  alu_res = readdata1 + op_b;
      OP_SUB:  alu_res = readdata1 - op_b;
      OP_AND:  alu_res = readdata1 & op_b;
      OP_OR:   alu_res = readdata1 | op_b;
      OP_XOR:  alu_res = readdata1 ^ op_b;
      OP_NOR:  alu_res = ~(readdata1 | op_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(readdata1) < $signed(op_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, readdata1 < op_b};
      OP_SLL:  alu_res = op_b << shamt;
      OP_SRL:  alu_res = op_b >> shamt;
      OP_SRA:  alu_res = $signed(op_b) >>> shamt;
      OP_LUI:  alu_res = op_b << 16;
      OP_MFHI: alu_res = hi_val;
      OP_MFLO: alu_res = lo_val;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result_out    <= '0;
      writedata_out     <= '0;
      branch_target_out <= '0;
      write_reg_out     <= '0;
      branch_taken_out  <= 1'b0;
      jump_out          <= 1'b0;
      MemRead_out       <= 1'b0;
      MemWrite_out      <= 1'b0;
      RegWrite_out      <= 1'b0;
      MemtoReg_out      <= 1'b0;
    end else if (stall) begin
      // bubble: kill side effects, leave data registers as they were
      branch_taken_out  <= 1'b0;
      jump_out          <= 1'b0;
      MemRead_out       <= 1'b0;
      MemWrite_out      <= 1'b0;
      RegWrite_out      <= 1'b0;
      MemtoReg_out      <= 1'b0;
    end else begin
      alu_result_out    <= alu_res;
      writedata_out     <= readdata2;
      branch_target_out <= npc + (sigext << 2);
      write_reg_out     <= RegDst ? instruction_1511 : instruction_2016;
      branch_taken_out  <= branch & (readdata1 == readdata2);
      jump_out          <= jump;
      MemRead_out       <= MemRead;
      MemWrite_out      <= MemWrite;
      RegWrite_out      <= RegWrite;
      MemtoReg_out      <= MemtoReg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; expectations adapt to whether EX_MULDIV_EN is defined.
`timescale 1ns/1ps
module tb_ex_stage;

  localparam logic [5:0] T_SLL = 6'h00, T_SRL = 6'h02, T_SRA = 6'h03, T_LUI = 6'h0F;
  localparam logic [5:0] T_MFHI = 6'h10, T_MFLO = 6'h12;
  localparam logic [5:0] T_MULT = 6'h18, T_MULTU = 6'h19, T_DIV = 6'h1A, T_DIVU = 6'h1B;
  localparam logic [5:0] T_ADD = 6'h20, T_SUB = 6'h22, T_AND = 6'h24, T_OR = 6'h25;
  localparam logic [5:0] T_XOR = 6'h26, T_NOR = 6'h27, T_SLT = 6'h2A, T_SLTU = 6'h2B;

`ifdef EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MD_CYCLES = MD_EN ? 33 : 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg;
  logic [5:0]  AluOp;
  logic [31:0] npc, readdata1, readdata2, sigext;
  logic [4:0]  instruction_2016, instruction_1511;
  logic        stall;
  logic [31:0] alu_result_out, writedata_out, branch_target_out;
  logic [4:0]  write_reg_out;
  logic        branch_taken_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .branch(branch), .jump(jump), .AluSrc(AluSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .AluOp(AluOp),
    .npc(npc), .readdata1(readdata1), .readdata2(readdata2), .sigext(sigext),
    .instruction_2016(instruction_2016), .instruction_1511(instruction_1511),
    .stall(stall), .alu_result_out(alu_result_out), .writedata_out(writedata_out),
    .branch_target_out(branch_target_out), .write_reg_out(write_reg_out),
    .branch_taken_out(branch_taken_out), .jump_out(jump_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out)
  );

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [63:0] ext;
    case (op)
      T_ADD:  return a + b;
      T_SUB:  return a - b;
      T_AND:  return a & b;
      T_OR:   return a | b;
      T_XOR:  return a ^ b;
      T_NOR:  return ~(a | b);
      T_SLT:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      T_SLTU: return {31'b0, a < b};
      T_SLL:  return b << sh;
      T_SRL:  return b >> sh;
      T_SRA:  begin ext = {{32{b[31]}}, b} >> sh; return ext[31:0]; end
      T_LUI:  return {b[15:0], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // returns {HI, LO}
  function automatic logic [63:0] ref_md(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      T_MULT:  begin p = sa * sb; return p; end
      T_MULTU: begin p = {32'h0, a} * {32'h0, b}; return p; end
      T_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      T_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet();
    {branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg} = '0;
    AluOp = T_ADD;
    npc = '0; readdata1 = '0; readdata2 = '0; sigext = '0;
    instruction_2016 = '0; instruction_1511 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg} = '1;
    AluOp = T_OR; npc = $urandom; readdata1 = 32'h55; readdata2 = 32'h55; sigext = $urandom;
    instruction_2016 = 5'd3; instruction_1511 = 5'd9;
    tick(); tick();
    total++;
    if (alu_result_out !== 32'h0 || writedata_out !== 32'h0 || branch_target_out !== 32'h0 ||
        write_reg_out !== 5'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", alu_result_out, writedata_out,
               branch_target_out, write_reg_out);
    end
    total++;
    if ({branch_taken_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out, stall} !== 7'h0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {branch_taken_out, jump_out, MemRead_out,
               MemWrite_out, RegWrite_out, MemtoReg_out, stall});
    end
    rst = 1'b1;
    set_quiet();
    tick();
  endtask

  task automatic test_add_wrap();
    set_quiet();
    AluOp = T_ADD; readdata1 = 32'h7FFF_FFFF; readdata2 = 32'h1;
    RegDst = 1'b1; instruction_1511 = 5'd5; instruction_2016 = 5'd2; RegWrite = 1'b1;
    tick();
    total++;
    if (alu_result_out !== 32'h8000_0000 || write_reg_out !== 5'd5 || RegWrite_out !== 1'b1) begin
      bad++;
      $display("FAIL add_wrap got=%h/%0d/%b exp=80000000/5/1", alu_result_out, write_reg_out, RegWrite_out);
    end
  endtask

  task automatic test_branch();
    set_quiet();
    branch = 1'b1; AluOp = T_SUB; readdata1 = 32'd3; readdata2 = 32'd3;
    npc = 32'h100; sigext = 32'hFFFF_FFFE;
    tick();
    total++;
    if (branch_taken_out !== 1'b1 || branch_target_out !== 32'hF8) begin
      bad++;
      $display("FAIL branch_taken got=%b/%h exp=1/000000f8", branch_taken_out, branch_target_out);
    end
    readdata2 = 32'd4;
    tick();
    total++;
    if (branch_taken_out !== 1'b0) begin
      bad++;
      $display("FAIL branch_not_taken got=%b exp=0", branch_taken_out);
    end
  endtask

  task automatic test_alu_random();
    logic [5:0] ops [14] = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR, T_SLT, T_SLTU,
                             T_SLL, T_SRL, T_SRA, T_LUI, T_ADD, T_SLT};
    for (int i = 0; i < 80; i++) begin
      logic [5:0]  op;
      logic [31:0] eb, er, et, ed;
      logic [4:0]  ew;
      logic [5:0]  ec;
      int unsigned k;
      k = $urandom_range(0, 17);
      if (k < 14) op = ops[k];
      else begin
        op = 6'($urandom);
        if (op inside {T_MFHI, T_MFLO, T_MULT, T_MULTU, T_DIV, T_DIVU}) op = 6'h3F;
      end
      AluOp = op;
      readdata1 = $urandom;
      readdata2 = ($urandom_range(0, 3) == 0) ? readdata1 : $urandom;
      sigext = $urandom; npc = $urandom;
      {branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg} = 8'($urandom);
      instruction_2016 = 5'($urandom); instruction_1511 = 5'($urandom);
      eb = AluSrc ? sigext : readdata2;
      er = ref_alu(op, readdata1, eb, sigext[10:6]);
      et = npc + {sigext[29:0], 2'b00};
      ed = readdata2;
      ew = RegDst ? instruction_1511 : instruction_2016;
      ec = {branch && (readdata1 == readdata2), jump, MemRead, MemWrite, RegWrite, MemtoReg};
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL alu_no_stall op=%h got=%b exp=0", op, stall);
      end
      tick();
      total++;
      if (alu_result_out !== er) begin
        bad++;
        $display("FAIL alu_result op=%h a=%h b=%h got=%h exp=%h", op, readdata1, eb, alu_result_out, er);
      end
      total++;
      if (branch_target_out !== et || writedata_out !== ed || write_reg_out !== ew) begin
        bad++;
        $display("FAIL alu_data got=%h/%h/%0d exp=%h/%h/%0d", branch_target_out, writedata_out,
                 write_reg_out, et, ed, ew);
      end
      total++;
      if ({branch_taken_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out} !== ec) begin
        bad++;
        $display("FAIL alu_ctrl got=%b exp=%b", {branch_taken_out, jump_out, MemRead_out,
                 MemWrite_out, RegWrite_out, MemtoReg_out}, ec);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [5:0]  ops [10] = '{T_MULT, T_DIVU, T_DIV, T_DIV, T_DIV, T_MULTU, T_MULT, T_DIV, T_DIVU, T_MULTU};
    logic [31:0] as  [10] = '{32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000,
                              32'hFFFF_FFFF, 0, 0, 0, 0};
    logic [31:0] bs  [10] = '{32'd7, 32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
    logic [5:0]  rops [4] = '{T_MULT, T_MULTU, T_DIV, T_DIVU};
    for (int i = 0; i < 10; i++) begin
      logic [63:0] exp_hl;
      int n;
      if (i >= 6) begin
        ops[i] = rops[$urandom_range(0, 3)];
        as[i] = $urandom;
        bs[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 5000)) : $urandom;
      end
      exp_hl = MD_EN ? ref_md(ops[i], as[i], bs[i]) : 64'h0;
      set_quiet();
      AluOp = ops[i]; readdata1 = as[i]; readdata2 = bs[i];
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL md_start_stall op=%h got=%b exp=0", ops[i], stall);
      end
      tick();
      total++;
      if (alu_result_out !== 32'h0 || RegWrite_out !== 1'b0) begin
        bad++;
        $display("FAIL md_start_retire got=%h/%b exp=0/0", alu_result_out, RegWrite_out);
      end
      AluOp = T_MFLO; RegWrite = 1'b1; RegDst = 1'b1; instruction_1511 = 5'd12;
      n = 0;
      #1;
      while (stall === 1'b1 && n < 100) begin
        tick();
        n++;
        total++;
        if (RegWrite_out !== 1'b0 || alu_result_out !== 32'h0) begin
          bad++;
          $display("FAIL md_bubble cyc=%0d got=%b/%h exp=0/0", n, RegWrite_out, alu_result_out);
        end
      end
      total++;
      if (n !== MD_CYCLES) begin
        bad++;
        $display("FAIL md_stall_len op=%h got=%0d exp=%0d", ops[i], n, MD_CYCLES);
      end
      tick();
      total++;
      if (alu_result_out !== exp_hl[31:0] || RegWrite_out !== 1'b1) begin
        bad++;
        $display("FAIL md_lo op=%h a=%h b=%h got=%h/%b exp=%h/1", ops[i], as[i], bs[i],
                 alu_result_out, RegWrite_out, exp_hl[31:0]);
      end
      AluOp = T_MFHI;
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL md_mfhi_stall got=%b exp=0", stall);
      end
      tick();
      total++;
      if (alu_result_out !== exp_hl[63:32]) begin
        bad++;
        $display("FAIL md_hi op=%h a=%h b=%h got=%h exp=%h", ops[i], as[i], bs[i],
                 alu_result_out, exp_hl[63:32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a2, b2;
    logic [63:0] exp_hl;
    int n;
    a2 = $urandom; b2 = $urandom;
    exp_hl = MD_EN ? ref_md(T_MULT, a2, b2) : 64'h0;
    set_quiet();
    AluOp = T_MULTU; readdata1 = $urandom; readdata2 = $urandom;
    tick();
    AluOp = T_MULT; readdata1 = a2; readdata2 = b2;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (n !== MD_CYCLES) begin
      bad++;
      $display("FAIL b2b_wait got=%0d exp=%0d", n, MD_CYCLES);
    end
    tick();
    AluOp = T_MFLO; RegWrite = 1'b1;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (n !== MD_CYCLES) begin
      bad++;
      $display("FAIL b2b_second_len got=%0d exp=%0d", n, MD_CYCLES);
    end
    tick();
    total++;
    if (alu_result_out !== exp_hl[31:0]) begin
      bad++;
      $display("FAIL b2b_lo got=%h exp=%h", alu_result_out, exp_hl[31:0]);
    end
  endtask

  task automatic test_independent();
    logic [31:0] da, db;
    logic [63:0] exp_hl;
    int n;
    da = 32'h4000_0000 | 32'($urandom); db = 32'($urandom_range(3, 999));
    exp_hl = MD_EN ? ref_md(T_DIVU, da, db) : 64'h0;
    set_quiet();
    AluOp = T_DIVU; readdata1 = da; readdata2 = db;
    tick();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] er;
      AluOp = (i % 2 == 0) ? T_ADD : T_XOR;
      readdata1 = $urandom; readdata2 = $urandom; RegWrite = 1'b1;
      er = ref_alu(AluOp, readdata1, readdata2, 5'd0);
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL indep_stall i=%0d got=%b exp=0", i, stall);
      end
      tick();
      total++;
      if (alu_result_out !== er || RegWrite_out !== 1'b1) begin
        bad++;
        $display("FAIL indep_result i=%0d got=%h/%b exp=%h/1", i, alu_result_out, RegWrite_out, er);
      end
    end
    AluOp = T_MFLO;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (n !== (MD_EN ? 28 : 0)) begin
      bad++;
      $display("FAIL indep_wait got=%0d exp=%0d", n, MD_EN ? 28 : 0);
    end
    tick();
    total++;
    if (alu_result_out !== exp_hl[31:0]) begin
      bad++;
      $display("FAIL indep_quot got=%h exp=%h", alu_result_out, exp_hl[31:0]);
    end
  endtask

  task automatic test_reset_abort();
    set_quiet();
    AluOp = T_MULT; readdata1 = 32'h1234_5678; readdata2 = 32'h0000_0ABC;
    npc = 32'h400; sigext = 32'h10; RegDst = 1'b1; instruction_1511 = 5'd17;
    tick();
    AluOp = T_MFHI; RegWrite = 1'b1; MemtoReg = 1'b1; jump = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    tick();
    total++;
    if (alu_result_out !== 32'h0 || writedata_out !== 32'h0 || branch_target_out !== 32'h0 ||
        write_reg_out !== 5'h0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs got=%h/%h/%h/%0d/%b exp=0", alu_result_out, writedata_out,
               branch_target_out, write_reg_out, stall);
    end
    rst = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle_stall got=%b exp=0", stall);
    end
    tick();
    total++;
    if (alu_result_out !== 32'h0 || RegWrite_out !== 1'b1) begin
      bad++;
      $display("FAIL abort_hi got=%h/%b exp=0/1", alu_result_out, RegWrite_out);
    end
    AluOp = T_MFLO;
    tick();
    total++;
    if (alu_result_out !== 32'h0) begin
      bad++;
      $display("FAIL abort_lo got=%h exp=0", alu_result_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_quiet();
    rst = 1'b1;
    test_reset();
    test_add_wrap();
    test_branch();
    test_alu_random();
    test_muldiv();
    test_back_to_back();
    test_independent();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipelined processor: consumes the ID/EX latch outputs, computes the ALU result, branch target/decision and destination register, and registers them into the EX/MEM boundary. Contains an iterative 32-cycle multiply/divide unit with HI/LO registers; it raises `stall` to freeze IF/ID/ID_EX while a dependent instruction waits for it.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous reset, active-low; sampled on posedge `clk`.
- `branch`, `jump`, `AluSrc`, `MemRead`, `MemWrite`, `RegWrite`, `RegDst`, `MemtoReg` in 1 each: control from ID/EX.
- `AluOp` in 6: operation code, encodings in package.
- `npc`, `readdata1`, `readdata2`, `sigext` in 32 each: PC+4, rs value, rt value, sign-extended immediate.
- `instruction_2016`, `instruction_1511` in 5 each: rt and rd fields.
- `stall` out 1: combinational; hold upstream stages this cycle.
- `alu_result_out`, `writedata_out`, `branch_target_out` out 32 each: registered results.
- `write_reg_out` out 5; `branch_taken_out`, `jump_out`, `MemRead_out`, `MemWrite_out`, `RegWrite_out`, `MemtoReg_out` out 1 each: registered.

## Operation
- Operand B = `AluSrc` ? `sigext` : `readdata2`; shift amount = `sigext[10:6]`.
- AluOp: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A (signed), SLTU 0x2B, SLL 0x00, SRL 0x02, SRA 0x03, LUI 0x0F (B<<16), MFHI 0x10, MFLO 0x12, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other code: result 0.
- ADD/SUB wrap modulo 2^32; no overflow trap.
- `branch_target` = `npc` + (`sigext` << 2), truncated to 32 bits; `branch_taken` = `branch` & (`readdata1` == `readdata2`).
- `write_reg` = `RegDst` ? `instruction_1511` : `instruction_2016`; `writedata` = `readdata2`.
- Mul/div FSM states IDLE, BUSY, FIX:
  - IDLE + MULT/MULTU/DIV/DIVU and not stalled: latch operand magnitudes (signed ops) or raw values, counter=0, go BUSY. The start instruction itself does not stall; it retires as a no-GPR-write op (result 0).
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; after step 31 go FIX.
  - FIX: apply sign (mul: negate 64-bit product if signs differ; div: LO quotient negated if signs differ, HI remainder takes dividend sign); write HI/LO; go IDLE.
  - Divide by zero: HI = dividend, LO = 0xFFFFFFFF, same 33-cycle timing.
- `stall` = (state != IDLE) & AluOp ∈ {MFHI, MFLO, MULT, MULTU, DIV, DIVU}. Independent ops flow during BUSY.
- While `stall`: EX/MEM control outputs (`RegWrite`, `MemRead`, `MemWrite`, `branch_taken`, `jump`, `MemtoReg`) register 0 (bubble); data outputs hold.

## Timing
- ALU/branch results appear on outputs one cycle after inputs are valid.
- Mul/div: start at edge N; BUSY edges N+1..N+32; FIX writes HI/LO at edge N+33; `stall` for a waiting MFHI/MFLO is low in the cycle after that edge, MFHI result registered on following edge.
- Back-to-back MULT while BUSY stalls until IDLE, then starts.
- Reset (`rst`=0 at edge): all outputs 0, HI=LO=0, state IDLE, counter 0, `stall` 0; aborts any operation in progress, no HI/LO update.

## Configuration
- `EX_MULDIV_EN` defined: mul/div unit, HI/LO and `stall` logic present as above.
- Undefined: no HI/LO or FSM; MULT/MULTU/DIV/DIVU/MFHI/MFLO yield result 0, `stall` tied 0.

## Structure
- Package `ex_pkg`: AluOp encoding constants, mul/div FSM state enum, `MULDIV_STEPS` = 32.
- Sub-module `ex_muldiv`: FSM, counter, HI/LO; interface start/op/operands in, busy/hi/lo out. ALU and output registers stay in `ex_stage`.

## Test plan
- ADD 0x7FFFFFFF + 1, RegDst=1, rd=5 -> next cycle alu_result 0x80000000, write_reg 5, RegWrite_out 1.
- branch=1, rs=rt=3, npc=0x100, sigext=0xFFFFFFFE -> branch_taken 1, branch_target 0xF8.
- MULT -3 × 7 then MFLO -> stall high 33 cycles, MFLO result 0xFFFFFFEB, MFHI 0xFFFFFFFF; bubbles have RegWrite_out 0.
- DIVU 7/0 then MFHI, MFLO -> HI 7, LO 0xFFFFFFFF.
- DIV in progress, independent ADD issued -> no stall, ADD result next cycle.
- rst low at BUSY cycle 10 -> state IDLE, HI/LO 0, all outputs 0, stall 0; without EX_MULDIV_EN, MULT -> result 0, stall never asserted.
